rule_conf_loader: RTL

RULE_CONF_LOADER -- requirements
Module: rule_conf_loader

---
 rtl/rule_conf_loader_if.sv | 23 ++
 rtl/rule_conf_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rule_conf_loader_if.sv
// ---------------------------------------------------------------------------
// rule_conf_loader_if
// Bundles the config-word handshake and the rule write bus of the loader.
//   i_cfg_valid / i_cfg_data / o_cfg_ready : config word stream into loader
//   i_hold                                 : parser busy, inhibits rule writes
//   o_rule_wren / o_rule_wdata / o_rule_addr : rule write strobe, data, address
// modport slave  : loader side
// modport master : config source / rule sink side
// ---------------------------------------------------------------------------
interface rule_conf_loader_if;
   logic        i_cfg_valid;
   logic [31:0] i_cfg_data;
   logic        o_cfg_ready;
   logic        i_hold;
   logic        o_rule_wren;
   logic [31:0] o_rule_wdata;
   logic [31:0] o_rule_addr;

   modport slave  (input  i_cfg_valid, i_cfg_data, i_hold,
                   output o_cfg_ready, o_rule_wren, o_rule_wdata, o_rule_addr);
   modport master (output i_cfg_valid, i_cfg_data, i_hold,
                   input  o_cfg_ready, o_rule_wren, o_rule_wdata, o_rule_addr);
endinterface

// File: rtl/rule_conf_loader.sv
// ---------------------------------------------------------------------------
// rule_conf_loader
// Buffers config words in a FIFO and turns header+data blocks into rule
// writes, optionally followed by a commit write to the rule id.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   bus (slave)    : config word handshake, i_hold, rule write bus
//   o_busy         : block in progress, words buffered or write in flight
//   o_done         : one-cycle pulse with the final write of a block
//   o_err          : sticky protocol error (bad header / timeout)
// Build option: define RULE_CONF_LOADER_TIMEOUT_EN to abort a block that sees
// TMO_CYCLES consecutive starved cycles in DATA.
// ---------------------------------------------------------------------------
module rule_conf_loader #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   rule_conf_loader_if.slave bus,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_COMMIT} state_t;

   typedef struct packed {
      logic [2:0]  magic;
      logic        commit;
      logic [3:0]  id;
      logic [7:0]  cnt;
      logic [15:0] addr;
   } hdr_t;

   // FIFO storage and pointers
   logic [FIFO_DEPTH-1:0][31:0] mem_q, mem_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // FIFO read register (the word the FSM works on this cycle)
   logic [31:0] rd_word_q, rd_word_d;
   logic        rd_vld_q, rd_vld_d;

   // block context
   state_t      state_q, state_d;
   logic [15:0] cur_addr_q, cur_addr_d;
   logic [7:0]  remain_q, remain_d;
   logic        commit_q, commit_d;
   logic [3:0]  id_q, id_d;

   // output registers
   logic        wren_q, wren_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

`ifdef RULE_CONF_LOADER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
   // TMO_CYCLES has no effect without the timeout build
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYCLES;
`endif

   logic push, pop, consume, fifo_empty;
   hdr_t hdr;

   assign hdr         = hdr_t'(rd_word_q);
   assign fifo_empty  = (count_q == '0);
   assign bus.o_cfg_ready = (count_q != FULL_CNT);
   assign push        = bus.i_cfg_valid & bus.o_cfg_ready;
   // COMMIT owns the write port for one cycle, so the read register is held
   assign consume     = rd_vld_q & ~bus.i_hold & (state_q != S_COMMIT);
   // refill the read register when it is empty or drained this cycle
   assign pop         = ~fifo_empty & ~bus.i_hold & (~rd_vld_q | consume);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_word_d  = rd_word_q;
      rd_vld_d   = rd_vld_q;
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      commit_d   = commit_q;
      id_d       = id_q;
      wren_d     = 1'b0;
      wdata_d    = wdata_q;
      addr_d     = addr_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef RULE_CONF_LOADER_TIMEOUT_EN
      tmo_cnt_d  = '0;
`endif

      if (push) begin
         mem_d[wr_ptr_q] = bus.i_cfg_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_word_d = mem_q[rd_ptr_q];
         rd_vld_d  = 1'b1;
         rd_ptr_d  = rd_ptr_q + AW'(1);
      end else if (consume) begin
         rd_vld_d = 1'b0;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (consume) begin
               if (hdr.magic == 3'b101 && hdr.cnt != 8'd0) begin
                  cur_addr_d = hdr.addr;
                  remain_d   = hdr.cnt;
                  commit_d   = hdr.commit;
                  id_d       = hdr.id;
                  state_d    = S_DATA;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (consume) begin
               wren_d     = 1'b1;
               wdata_d    = rd_word_q;
               addr_d     = {16'h0, cur_addr_q};
               // only the low byte advances; the page byte is fixed per block
               cur_addr_d = {cur_addr_q[15:8], cur_addr_q[7:0] + 8'd1};
               remain_d   = remain_q - 8'd1;
               if (remain_q == 8'd1) begin
                  if (commit_q) begin
                     state_d = S_COMMIT;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
`ifdef RULE_CONF_LOADER_TIMEOUT_EN
            else if (~rd_vld_q && fifo_empty && ~bus.i_hold) begin
               if (tmo_cnt_q == TW'(TMO_CYCLES - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TW'(1);
               end
            end
`endif
         end
         S_COMMIT: begin
            if (~bus.i_hold) begin
               wren_d  = 1'b1;
               wdata_d = 32'h1;
               addr_d  = {28'h0, id_q};
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_word_q  <= '0;
         rd_vld_q   <= 1'b0;
         state_q    <= S_IDLE;
         cur_addr_q <= '0;
         remain_q   <= '0;
         commit_q   <= 1'b0;
         id_q       <= '0;
         wren_q     <= 1'b0;
         wdata_q    <= '0;
         addr_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef RULE_CONF_LOADER_TIMEOUT_EN
         tmo_cnt_q  <= '0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_word_q  <= rd_word_d;
         rd_vld_q   <= rd_vld_d;
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         remain_q   <= remain_d;
         commit_q   <= commit_d;
         id_q       <= id_d;
         wren_q     <= wren_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef RULE_CONF_LOADER_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
`endif
      end
   end

   assign bus.o_rule_wren  = wren_q;
   assign bus.o_rule_wdata = wdata_q;
   assign bus.o_rule_addr  = addr_q;
   assign o_done           = done_q;
   assign o_err            = err_q;
   // the read register is the FIFO's output stage, so it counts as buffered
   assign o_busy = (state_q != S_IDLE) | ~fifo_empty | rd_vld_q | wren_q;

endmodule
